// File: rtl/ace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ace_pkg
// Description : Shared ACE snoop-response definitions for the CCU snoop
//               response merge block: CR bit positions, merge FSM state
//               encoding and the CR response merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ace_pkg;

  localparam int unsigned CrWidth        = 5;
  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  typedef enum logic [1:0] {
    MRG_IDLE  = 2'd0,
    MRG_BCAST = 2'd1,
    MRG_RESP  = 2'd2,
    MRG_DATA  = 2'd3
  } merge_state_e;

  // WasUnique, IsShared, Error and DataTransfer combine by OR. PassDirty is
  // not an OR: it belongs to the single master whose data is forwarded, so
  // it is cleared here and re-inserted from the selected responder.
  function automatic logic [CrWidth-1:0] merge_crresp(input logic [CrWidth-1:0] a,
                                                      input logic [CrWidth-1:0] b);
    logic [CrWidth-1:0] r;
    r              = a | b;
    r[CrPassDirty] = 1'b0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccu_cd_drain.sv
`default_nettype none
// ============================================================================
// Module      : ccu_cd_drain
// Description : Per-port CD burst tracker. Remembers that a master answered
//               with DataTransfer and stays pending until that master's last
//               CD beat is handshaken.
// Ports       : clk_i, rst_ni  - clock, asynchronous active-low reset
//               clr_i          - new snoop accepted, forget previous state
//               set_i          - CR with DataTransfer accepted from this port
//               hs_last_i      - last CD beat handshaken on this port
//               pend_o         - a CD burst is still owed by this port
// Revision    : 1.0 - initial release
// ============================================================================
module ccu_cd_drain (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic set_i,
  input  logic hs_last_i,
  output logic pend_o
);

  logic r_pend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= 1'b0;
    end else if (clr_i) begin
      r_pend <= 1'b0;
    end else if (set_i) begin
      r_pend <= 1'b1;
    end else if (hs_last_i) begin
      r_pend <= 1'b0;
    end
  end

  assign pend_o = r_pend;

endmodule
`default_nettype wire

// File: rtl/ccu_snoop_resp_merge.sv
`default_nettype none
// ============================================================================
// Module      : ccu_snoop_resp_merge
// Description : Broadcasts one AC snoop to the masters in a domain mask,
//               merges their CR responses into one upstream CR, forwards the
//               CD burst of one selected master and drains all other bursts.
//               One snoop outstanding at a time.
// Ports       : clk_i/rst_ni            clock, async active-low reset
//               ac_*, domain_mask_i     upstream snoop request
//               cr_*                    merged upstream response
//               cd_*                    upstream data burst
//               mst_ac_*/mst_cr_*/mst_cd_*  per-master snoop channels
// Options     : CCU_SNOOP_RESP_MERGE_BYPASS_EN - answer a zero-mask snoop
//               combinationally in IDLE instead of via the RESP state.
// Revision    : 1.0 - initial release
// ============================================================================
module ccu_snoop_resp_merge
  import ace_pkg::*;
#(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned AcWidth    = 48,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned CdBeats    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ac_valid_i,
  output logic                          ac_ready_o,
  input  logic [AcWidth-1:0]            ac_i,
  input  logic [NoMstPorts-1:0]         domain_mask_i,
  output logic                          cr_valid_o,
  input  logic                          cr_ready_i,
  output logic [CrWidth-1:0]            cr_resp_o,
  output logic                          cd_valid_o,
  input  logic                          cd_ready_i,
  output logic [DataWidth-1:0]          cd_data_o,
  output logic                          cd_last_o,
  output logic [NoMstPorts-1:0]         mst_ac_valid_o,
  input  logic [NoMstPorts-1:0]         mst_ac_ready_i,
  output logic [AcWidth-1:0]            mst_ac_o,
  input  logic [NoMstPorts-1:0]         mst_cr_valid_i,
  output logic [NoMstPorts-1:0]         mst_cr_ready_o,
  input  logic [CrWidth*NoMstPorts-1:0] mst_cr_resp_i,
  input  logic [NoMstPorts-1:0]         mst_cd_valid_i,
  output logic [NoMstPorts-1:0]         mst_cd_ready_o,
  input  logic [DataWidth*NoMstPorts-1:0] mst_cd_data_i,
  input  logic [NoMstPorts-1:0]         mst_cd_last_i
);

  localparam int unsigned SelW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;
  localparam int unsigned CntW = $clog2(CdBeats) + 1;

  merge_state_e            r_state, w_state_nxt;
  logic [AcWidth-1:0]      r_ac;
  logic [NoMstPorts-1:0]   r_mask, r_ac_pend, r_cr_pend, r_pd;
  logic [NoMstPorts-1:0]   w_dt, w_pd_bit, w_dt_bit;
  logic [NoMstPorts-1:0]   w_ac_hs, w_cr_hs, w_cd_hs, w_cd_last_hs;
  logic [CrWidth-1:0]      r_merged, w_merged_nxt, w_resp;
  logic [SelW-1:0]         r_sel, w_sel;
  logic [CntW-1:0]         r_beat_cnt;
  logic                    w_ac_acc, w_bcast, w_data;

  assign w_bcast = (r_state == MRG_BCAST);
  assign w_data  = (r_state == MRG_DATA);

  assign mst_ac_o       = r_ac;
  assign mst_ac_valid_o = w_bcast ? r_ac_pend : '0;
  // A master's CR is only taken once its own AC has been handshaken.
  assign mst_cr_ready_o = w_bcast ? (r_cr_pend & ~r_ac_pend & r_mask) : '0;

  assign w_ac_hs      = mst_ac_valid_o & mst_ac_ready_i;
  assign w_cr_hs      = mst_cr_ready_o & mst_cr_valid_i;
  assign w_cd_hs      = mst_cd_ready_o & mst_cd_valid_i;
  assign w_cd_last_hs = w_cd_hs & mst_cd_last_i;

  always_comb begin
    w_merged_nxt = r_merged;
    w_pd_bit     = '0;
    w_dt_bit     = '0;
    for (int i = 0; i < int'(NoMstPorts); i++) begin
      w_pd_bit[i] = mst_cr_resp_i[i*CrWidth+CrPassDirty];
      w_dt_bit[i] = mst_cr_resp_i[i*CrWidth+CrDataTransfer];
      if (w_cr_hs[i]) begin
        w_merged_nxt = merge_crresp(w_merged_nxt, mst_cr_resp_i[i*CrWidth +: CrWidth]);
      end
    end
  end

  // Data source: lowest PassDirty responder, else lowest DataTransfer one.
  // Scanning high to low lets the lowest index win; the PassDirty scan runs
  // second so it overrides any DataTransfer-only choice.
  always_comb begin
    w_sel = '0;
    for (int i = int'(NoMstPorts) - 1; i >= 0; i--) begin
      if (w_dt[i]) w_sel = SelW'(i);
    end
    for (int i = int'(NoMstPorts) - 1; i >= 0; i--) begin
      if (r_pd[i]) w_sel = SelW'(i);
    end
    w_resp              = r_merged;
    w_resp[CrPassDirty] = r_pd[w_sel];
  end

  generate
    for (genvar g = 0; g < int'(NoMstPorts); g++) begin : g_drain
      ccu_cd_drain u_drain (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (w_ac_acc),
        .set_i     (w_cr_hs[g] & w_dt_bit[g]),
        .hs_last_i (w_cd_last_hs[g]),
        .pend_o    (w_dt[g])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    ac_ready_o  = 1'b0;
    cr_valid_o  = 1'b0;
    cr_resp_o   = '0;
    w_ac_acc    = 1'b0;
    case (r_state)
      MRG_IDLE: begin
        ac_ready_o = 1'b1;
`ifdef CCU_SNOOP_RESP_MERGE_BYPASS_EN
        if (ac_valid_i && (domain_mask_i == '0)) begin
          // Nobody to snoop: answer with an empty response in the same cycle.
          ac_ready_o = cr_ready_i;
          cr_valid_o = 1'b1;
        end else if (ac_valid_i) begin
          w_ac_acc    = 1'b1;
          w_state_nxt = MRG_BCAST;
        end
`else
        if (ac_valid_i) begin
          w_ac_acc    = 1'b1;
          w_state_nxt = (domain_mask_i != '0) ? MRG_BCAST : MRG_RESP;
        end
`endif
      end
      MRG_BCAST: begin
        if (((r_ac_pend & ~w_ac_hs) == '0) && ((r_cr_pend & ~w_cr_hs) == '0)) begin
          w_state_nxt = MRG_RESP;
        end
      end
      MRG_RESP: begin
        cr_valid_o = 1'b1;
        cr_resp_o  = w_resp;
        if (cr_ready_i) begin
          w_state_nxt = (w_dt != '0) ? MRG_DATA : MRG_IDLE;
        end
      end
      MRG_DATA: begin
        // Selected burst and all drains may finish in either order.
        if ((w_dt & ~w_cd_last_hs) == '0) begin
          w_state_nxt = MRG_IDLE;
        end
      end
      default: w_state_nxt = MRG_IDLE;
    endcase
  end

  always_comb begin
    mst_cd_ready_o = '0;
    cd_valid_o     = 1'b0;
    cd_data_o      = mst_cd_data_i[r_sel*DataWidth +: DataWidth];
    cd_last_o      = mst_cd_last_i[r_sel];
    if (w_data) begin
      cd_valid_o = mst_cd_valid_i[r_sel] & w_dt[r_sel];
      for (int i = 0; i < int'(NoMstPorts); i++) begin
        mst_cd_ready_o[i] = w_dt[i] & ((SelW'(i) == r_sel) ? cd_ready_i : 1'b1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= MRG_IDLE;
      r_ac       <= '0;
      r_mask     <= '0;
      r_ac_pend  <= '0;
      r_cr_pend  <= '0;
      r_pd       <= '0;
      r_merged   <= '0;
      r_sel      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ac_acc) begin
        r_ac      <= ac_i;
        r_mask    <= domain_mask_i;
        r_ac_pend <= domain_mask_i;
        r_cr_pend <= domain_mask_i;
        r_pd      <= '0;
        r_merged  <= '0;
      end else begin
        r_ac_pend <= r_ac_pend & ~w_ac_hs;
        r_cr_pend <= r_cr_pend & ~w_cr_hs;
        r_pd      <= r_pd | (w_cr_hs & w_pd_bit);
        r_merged  <= w_merged_nxt;
      end
      if ((r_state == MRG_RESP) && cr_ready_i) begin
        r_sel      <= w_sel;
        r_beat_cnt <= '0;
      end else if (w_data && w_cd_hs[r_sel]) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ccu_snoop_resp_merge.md
Name: ccu_snoop_resp_merge

Overview:
- Sits between the CCU read-snoop control FSM and the N snooped cached masters.
- Broadcasts one AC request to the masters selected by a domain mask.
- Collects and merges their CR responses into one CR response upstream.
- Forwards exactly one CD burst upstream and silently drains any other CD bursts.
- One snoop is outstanding at a time; it is serialised per snoop.

Parameters:
- NoMstPorts, 4, number of snooped cached masters (>=1).
- AcWidth, 48, packed AC payload width (addr, snoop, prot), treated as opaque.
- DataWidth, 64, CD data width.
- CdBeats, 4, beats per CD burst; used only by the beat counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ac_valid_i  in  1  upstream AC valid
- ac_ready_o  out  1  upstream AC ready
- ac_i  in  AcWidth  upstream AC payload
- domain_mask_i  in  NoMstPorts  masters to snoop; valid with ac_valid_i
- cr_valid_o  out  1  merged CR valid
- cr_ready_i  in  1  merged CR ready
- cr_resp_o  out  5  merged CR {WasUnique,IsShared,PassDirty,Error,DataTransfer}
- cd_valid_o  out  1  upstream CD valid
- cd_ready_i  in  1  upstream CD ready
- cd_data_o  out  DataWidth  upstream CD data
- cd_last_o  out  1  upstream CD last
- mst_ac_valid_o  out  NoMstPorts  per-master AC valid
- mst_ac_ready_i  in  NoMstPorts  per-master AC ready
- mst_ac_o  out  AcWidth  broadcast AC payload (latched copy)
- mst_cr_valid_i  in  NoMstPorts  per-master CR valid
- mst_cr_ready_o  out  NoMstPorts  per-master CR ready
- mst_cr_resp_i  in  5*NoMstPorts  per-master CR
- mst_cd_valid_i  in  NoMstPorts  per-master CD valid
- mst_cd_ready_o  out  NoMstPorts  per-master CD ready
- mst_cd_data_i  in  DataWidth*NoMstPorts  per-master CD data
- mst_cd_last_i  in  NoMstPorts  per-master CD last

Behaviour:
- Reset: state IDLE. All valid/ready outputs are 0 except ac_ready_o=1. Latched AC, mask, pending vectors and merged response are 0.
- FSM states: IDLE, BCAST, RESP, DATA.
- IDLE:
  - ac_ready_o=1.
  - On handshake, latch ac_i and domain_mask_i. Set ac_pend=cr_pend=mask.
  - Mask nonzero -> BCAST. Mask zero -> RESP with merged=0.
- BCAST:
  - mst_ac_valid_o=ac_pend. Each mst_ac handshake clears its ac_pend bit.
  - mst_cr_ready_o[i] = cr_pend[i] & ~ac_pend[i]. A CR is never accepted before its own AC.
  - On CR handshake, clear cr_pend[i] and OR the CR into the merge.
  - Record dt[i] (DataTransfer) and pd[i] (PassDirty).
  - Exit to RESP the cycle after ac_pend==0 and cr_pend==0.
  - Same-cycle AC and CR handshakes on different ports are allowed.
- Merge rules:
  - WasUnique, IsShared and Error are the OR over responders.
  - DataTransfer is the OR of dt.
  - sel = lowest index with pd, else lowest index with dt.
  - PassDirty = pd[sel].
- RESP:
  - cr_valid_o=1 with cr_resp_o stable until cr_ready_i.
  - On handshake: if any dt -> DATA, else IDLE.
- DATA:
  - cd_valid_o = mst_cd_valid_i[sel], with data and last passed through combinationally.
  - mst_cd_ready_o[sel] = cd_ready_i.
  - For every other i with dt[i], mst_cd_ready_o[i]=1 until its last beat (drain); those bits then clear.
  - Return to IDLE when the selected master's last handshake is done and all drains are done; these may complete in either order.
  - CD from a master without dt is never accepted (ready=0).
- Beat counter (log2(CdBeats)+1 bits) counts selected-master beats, cleared on entry to DATA.
- Latency: AC accept to first mst_ac_valid_o is 1 cycle; last CR to cr_valid_o is 1 cycle.
- Reset mid-operation aborts immediately to the reset state. No partial CR/CD is emitted afterwards.

Optional Feature:
- Macro: CCU_SNOOP_RESP_MERGE_BYPASS_EN.
- Defined: in IDLE with ac_valid_i=1 and domain_mask_i==0:
  - cr_valid_o=1 and cr_resp_o=0 combinationally;
  - ac_ready_o=cr_ready_i;
  - no state change (zero-cycle response).
- Undefined: the zero mask goes through RESP, so cr_valid_o rises 1 cycle after the AC handshake.

Decomposition:
- ace_pkg holds:
  - the CR bit-index constants (CrDataTransfer=0 … CrWasUnique=4);
  - the merge state enum;
  - a function merge_crresp(a,b) implementing the OR rules.
- One sub-module, ccu_cd_drain: per-port drain tracker (dt bit, clear on last handshake). Instantiated NoMstPorts times.

Test Plan:
- Mask 4'b0110, both CRs 5'b01000 (IsShared, no data) -> cr_resp_o=5'b01000 one cycle after the last CR; no cd_valid_o; back to IDLE.
- Mask 4'b1110; master1 CR 5'b01001, master3 CR 5'b00101 (PassDirty+DT) -> sel=3, cr_resp_o=5'b01101. Four master3 beats forwarded with cd_last_o on beat 4; master1's four beats drained; IDLE only after both finish.
- Mask 4'b0011 with master0 mst_ac_ready_i held low for 5 cycles while master1 CR returns at once -> master1 CR accepted; master0 CR ready stays 0 until its AC handshake; single merged CR.
- Mask 0 -> cr_resp_o=0.
  - Macro undefined: cr_valid_o 1 cycle after the AC handshake.
  - Macro defined: same cycle as ac_valid_i, with ac_ready_o following cr_ready_i.
- cr_ready_i low 3 cycles in RESP; then in DATA toggle cd_ready_i -> cr_resp_o stable; upstream CD beats match the selected master's data in order.
- Assert rst_ni mid-DATA (after 2 beats) -> all valids 0, ac_ready_o=1 after release; the next snoop completes normally.
